// File: rtl/led_scroll_ctrl_if.sv
// led_scroll_ctrl_if: host and LED-decoder facing signals of the scrolling display controller
interface led_scroll_ctrl_if;
  logic wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic start;
  logic stop;
  logic home;
  logic busy;
  logic [3:0] pos;
  logic an3;
  logic an2;
  logic an1;
  logic an0;
  logic [3:0] char;
  modport master (
    output wr_en, wr_addr, wr_data, start, stop, home,
    input busy, pos, an3, an2, an1, an0, char
  );
  modport slave (
    input wr_en, wr_addr, wr_data, start, stop, home,
    output busy, pos, an3, an2, an1, an0, char
  );
endinterface

// File: rtl/led_scroll_ctrl.sv
// led_scroll_ctrl: 4-digit multiplexed LED refresh with a scrolling window over a 16-entry message buffer
module led_scroll_ctrl #(
  parameter int MSG_LEN = 16,
  parameter int STEP_FRAMES = 4
) (
  input logic clk,
  input logic reset,
  led_scroll_ctrl_if.slave bus
);
  localparam int FW = STEP_FRAMES > 1 ? $clog2(STEP_FRAMES) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [3:0] ref_cnt;
  logic [3:0] pos;
  logic [3:0] char_q;
  logic [FW-1:0] frame_cnt;
  logic [3:0] mem [16];
  logic [4:0] sum;
  logic [3:0] rd_addr;
  logic strobe;
  logic frame_end;
  logic step;
  logic [3:0] pos_next;
  // Digit d = ~ref_cnt[3:2] so the leftmost digit is strobed first in each frame.
  assign sum = {1'b0, pos} + {3'b0, ~ref_cnt[3:2]};
  assign rd_addr = 4'(sum % 5'(MSG_LEN));
  assign strobe = ref_cnt[1:0] == 2'b10;
  assign frame_end = ref_cnt == 4'd0;
  assign step = state == RUN && frame_end && frame_cnt == FW'(STEP_FRAMES - 1);
  assign pos_next = pos == 4'(MSG_LEN - 1) ? 4'd0 : pos + 4'd1;
  assign bus.an3 = !(strobe && ref_cnt[3:2] == 2'b11);
  assign bus.an2 = !(strobe && ref_cnt[3:2] == 2'b10);
  assign bus.an1 = !(strobe && ref_cnt[3:2] == 2'b01);
  assign bus.an0 = !(strobe && ref_cnt[3:2] == 2'b00);
  assign bus.char = char_q;
  assign bus.pos = pos;
  assign bus.busy = state == RUN;
  // Message buffer writes and per-digit character load; a same-cycle write/load sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      char_q <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (ref_cnt[1:0] == 2'b11) char_q <= mem[rd_addr];
      if (bus.wr_en && {1'b0, bus.wr_addr} < 5'(MSG_LEN)) mem[bus.wr_addr] <= bus.wr_data;
    end
  end
  // Refresh counter, run/idle control and scroll position; pos moves only on frame boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= 4'd15;
      state <= IDLE;
      pos <= '0;
      frame_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt - 4'd1;
      state <= bus.stop ? IDLE : (bus.start ? RUN : state);
      if (bus.home) begin
        pos <= '0;
        frame_cnt <= '0;
      end else if (state == IDLE && bus.start && !bus.stop) begin
        frame_cnt <= '0;
      end else if (step) begin
        pos <= pos_next;
        frame_cnt <= '0;
      end else if (state == RUN && frame_end) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_scroll_ctrl.sv
// tb_led_scroll_ctrl: scoreboard bench driving a 16-char/2-frame and a 5-char/1-frame controller in lockstep
module tb_led_scroll_ctrl;
  typedef struct packed {
    logic [3:0] an;
    logic [3:0] ch;
    logic [3:0] pos;
    logic busy;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] rc;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  led_scroll_ctrl_if b0();
  led_scroll_ctrl_if b1();
  assign b1.wr_en = b0.wr_en;
  assign b1.wr_addr = b0.wr_addr;
  assign b1.wr_data = b0.wr_data;
  assign b1.start = b0.start;
  assign b1.stop = b0.stop;
  assign b1.home = b0.home;
  led_scroll_ctrl #(.MSG_LEN(16), .STEP_FRAMES(2)) u0 (.clk(clk), .reset(reset), .bus(b0));
  led_scroll_ctrl #(.MSG_LEN(5), .STEP_FRAMES(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;
  // Bench-side refresh phase so stimulus can align with frames.
  always @(posedge clk) rc <= reset ? 4'd15 : rc - 4'd1;
  // Monitors: every strobe with an expectation queued is popped and compared.
  always @(negedge clk) begin
    exp_t g;
    exp_t e;
    g = {b0.an3, b0.an2, b0.an1, b0.an0, b0.char, b0.pos, b0.busy};
    if (g.an != 4'hf && q0.size() > 0) begin
      e = q0.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL strobe_u0 got an=%b ch=%0d pos=%0d busy=%b, expected an=%b ch=%0d pos=%0d busy=%b",
                 g.an, g.ch, g.pos, g.busy, e.an, e.ch, e.pos, e.busy);
      end
    end
  end
  always @(negedge clk) begin
    exp_t g;
    exp_t e;
    g = {b1.an3, b1.an2, b1.an1, b1.an0, b1.char, b1.pos, b1.busy};
    if (g.an != 4'hf && q1.size() > 0) begin
      e = q1.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL strobe_u1 got an=%b ch=%0d pos=%0d busy=%b, expected an=%b ch=%0d pos=%0d busy=%b",
                 g.an, g.ch, g.pos, g.busy, e.an, e.ch, e.pos, e.busy);
      end
    end
  end
  task automatic push(input int u, input int p, input bit bz, input bit full, input int c0);
    int l;
    l = u != 0 ? 5 : 16;
    for (int d = 0; d < 4; d++) begin
      exp_t e;
      int c;
      c = full ? (p + d) % l : 0;
      if (d == 0 && c0 >= 0) c = c0;
      e.an = ~(4'b1000 >> d);
      e.ch = 4'(c);
      e.pos = 4'(p);
      e.busy = bz;
      if (u != 0) q1.push_back(e);
      else q0.push_back(e);
    end
  endtask
  task automatic pb(input int p0, input int p1, input bit bz, input bit full, input int c0);
    push(0, p0, bz, full, c0);
    push(1, p1, bz, full, c0);
  endtask
  task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %b expected %b", nm, got, exp);
    end
  endtask
  task automatic to_next15();
    @(negedge clk);
    while (rc != 4'd15) @(negedge clk);
  endtask
  task automatic to_rc(input logic [3:0] v);
    while (rc != v) @(negedge clk);
  endtask
  task automatic chk_reset();
    chk("reset_u0", {b0.an3, b0.an2, b0.an1, b0.an0, b0.char, b0.pos, b0.busy}, 13'b1111_0000_0000_0);
    chk("reset_u1", {b1.an3, b1.an2, b1.an1, b1.an0, b1.char, b1.pos, b1.busy}, 13'b1111_0000_0000_0);
  endtask
  task automatic chk_busy(input string nm, input logic v);
    chk({nm, "_u0"}, {12'd0, b0.busy}, {12'd0, v});
    chk({nm, "_u1"}, {12'd0, b1.busy}, {12'd0, v});
  endtask
  initial begin
    int p0;
    int p1;
    b0.wr_en = 1'b0;
    b0.wr_addr = '0;
    b0.wr_data = '0;
    b0.start = 1'b0;
    b0.stop = 1'b0;
    b0.home = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset();
    pb(0, 0, 1'b0, 1'b0, -1);
    to_next15();
    for (int i = 0; i < 16; i++) begin
      b0.wr_en = 1'b1;
      b0.wr_addr = 4'(i);
      b0.wr_data = 4'(i);
      @(negedge clk);
    end
    b0.wr_en = 1'b0;
    pb(0, 0, 1'b0, 1'b1, -1);
    to_next15();
    b0.wr_en = 1'b1;
    b0.wr_addr = 4'd0;
    b0.wr_data = 4'd9;
    pb(0, 0, 1'b0, 1'b1, 0);
    @(negedge clk);
    b0.wr_en = 1'b0;
    to_next15();
    b0.wr_en = 1'b1;
    b0.wr_data = 4'd0;
    pb(0, 0, 1'b0, 1'b1, 9);
    @(negedge clk);
    b0.wr_en = 1'b0;
    to_next15();
    pb(0, 0, 1'b0, 1'b1, -1);
    to_rc(4'd1);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    chk_busy("busy_after_start", 1'b1);
    for (int k = 1; k <= 40; k++) begin
      to_next15();
      b0.home = 1'b0;
      p0 = k < 36 ? (k / 2) % 16 : ((k - 36) / 2) % 16;
      p1 = k < 36 ? k % 5 : (k - 36) % 5;
      pb(p0, p1, 1'b1, 1'b1, -1);
      if (k == 35) begin
        to_rc(4'd0);
        b0.home = 1'b1;
      end
    end
    to_rc(4'd1);
    b0.stop = 1'b1;
    @(negedge clk);
    b0.stop = 1'b0;
    chk_busy("busy_after_stop", 1'b0);
    to_next15();
    pb(2, 4, 1'b0, 1'b1, -1);
    to_rc(4'd10);
    b0.start = 1'b1;
    b0.stop = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    b0.stop = 1'b0;
    chk_busy("busy_start_stop", 1'b0);
    to_next15();
    pb(2, 4, 1'b0, 1'b1, -1);
    to_rc(4'd1);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    chk_busy("busy_restart", 1'b1);
    to_next15();
    pb(2, 0, 1'b1, 1'b1, -1);
    to_next15();
    pb(3, 1, 1'b1, 1'b1, -1);
    to_next15();
    pb(3, 2, 1'b1, 1'b1, -1);
    to_rc(4'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset();
    pb(0, 0, 1'b0, 1'b0, -1);
    to_next15();
    pb(0, 0, 1'b0, 1'b0, -1);
    to_next15();
    n_cmp++;
    if (q0.size() + q1.size() != 0) begin
      n_bad++;
      $display("FAIL strobe_drain got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
